// File: rtl/shared_mem_port.sv
// shared_mem_port
//   Processor-side requester for one port of the shared scratchpad. It takes
//   one load/store command from a SIMD core and drives the scratchpad request
//   lines until the arbiter grants the port. Read data is captured from the
//   shared read bus and returned to the core. Writes are posted and produce
//   no response.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready   command channel from the core
//   o_rsp_*/i_rsp_ready   read response channel to the core
//   o_req_rd/o_req_wr     request lines to the scratchpad arbiter
//   i_grant_rd/i_grant_wr grant lines from the arbiter for this port
//   o_addr/o_wr_data/o_wr_size  held command fields driven to the scratchpad
//   i_rd_data             shared scratchpad read bus
//   o_stall_cnt/i_stall_clr     saturating count of ungranted request cycles
//   o_dbg_state           current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised it stays high, with its payload stable,
// until that transfer; ready may be raised or dropped at any time.
module shared_mem_port #(
    parameter int BUS_SIZE   = 160,
    parameter int UNIT_SIZE  = 32,
    parameter int ADDR_SIZE  = 24,
    parameter int RD_LATENCY = 1,
    parameter int STALL_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [ADDR_SIZE-1:0] i_cmd_addr,
    input  logic [BUS_SIZE-1:0]  i_cmd_wdata,
    input  logic [2:0]           i_cmd_wr_size,
    output logic                 o_rsp_valid,
    output logic [BUS_SIZE-1:0]  o_rsp_data,
    input  logic                 i_rsp_ready,
    output logic                 o_req_rd,
    output logic                 o_req_wr,
    input  logic                 i_grant_rd,
    input  logic                 i_grant_wr,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic [BUS_SIZE-1:0]  o_wr_data,
    output logic [2:0]           o_wr_size,
    input  logic [BUS_SIZE-1:0]  i_rd_data,
    output logic [STALL_W-1:0]   o_stall_cnt,
    input  logic                 i_stall_clr,
    output logic [2:0]           o_dbg_state
);

    // Elaboration-time sanity check on the configuration.
    if (RD_LATENCY < 0 || RD_LATENCY > 7 || (BUS_SIZE % UNIT_SIZE) != 0) begin : g_bad_params
        $error("shared_mem_port: RD_LATENCY must be 0..7 and BUS_SIZE a multiple of UNIT_SIZE");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_RD  = 3'd1,
        REQ_WR  = 3'd2,
        RD_WAIT = 3'd3,
        RSP     = 3'd4
    } state_t;

    // The grant cycle itself is the first latency cycle, so the wait counter
    // starts one below RD_LATENCY and the data is sampled when it reaches 0.
    localparam logic [2:0] WAIT_INIT = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

    state_t      state;
    state_t      state_next;
    logic [2:0]  wait_cnt;
    logic        load_cmd;
    logic        load_wait;
    logic        capture_rd;
    logic        stall_evt;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // Next state and Moore outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_next  = state;
        o_cmd_ready = 1'b0;
        o_req_rd    = 1'b0;
        o_req_wr    = 1'b0;
        o_rsp_valid = 1'b0;
        load_cmd    = 1'b0;
        load_wait   = 1'b0;
        capture_rd  = 1'b0;
        stall_evt   = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    load_cmd   = 1'b1;
                    state_next = i_cmd_we ? REQ_WR : REQ_RD;
                end
            end
            REQ_RD: begin
                o_req_rd = 1'b1;
                // A write grant here belongs to nobody we care about.
                if (i_grant_rd) begin
                    if (RD_LATENCY == 0) begin
                        capture_rd = 1'b1;
                        state_next = RSP;
                    end else begin
                        load_wait  = 1'b1;
                        state_next = RD_WAIT;
                    end
                end else begin
                    stall_evt = 1'b1;
                end
            end
            REQ_WR: begin
                o_req_wr = 1'b1;
                if (i_grant_wr) begin
                    state_next = IDLE;
                end else begin
                    stall_evt = 1'b1;
                end
            end
            RD_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    capture_rd = 1'b1;
                    state_next = RSP;
                end
            end
            RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_dbg_state = state;

    // ---------------------------------------------------------------
    // Command fields: loaded on acceptance, held through RD_WAIT/RSP so a
    // memory that registers its address still sees a stable value.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_addr    <= '0;
            o_wr_data <= '0;
            o_wr_size <= '0;
        end else if (load_cmd) begin
            o_addr    <= i_cmd_addr;
            o_wr_data <= i_cmd_wdata;
            o_wr_size <= i_cmd_wr_size;
        end
    end

    // ---------------------------------------------------------------
    // Read latency counter and response capture
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= 3'd0;
        end else if (load_wait) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == RD_WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // The read bus is shared, so it is sampled only in the one cycle that
    // belongs to this port; later bus activity never reaches o_rsp_data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_data <= '0;
        end else if (capture_rd) begin
            o_rsp_data <= i_rd_data;
        end
    end

    // ---------------------------------------------------------------
    // Stall counter: clear wins over increment; saturates at all-ones.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (i_stall_clr) begin
            o_stall_cnt <= '0;
        end else if (stall_evt && (o_stall_cnt != {STALL_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_shared_mem_port.sv
// Testbench for shared_mem_port (RD_LATENCY=1, STALL_W=4).
// A cycle table covers reset, a posted write and a stalled read; hand-written
// sequences cover backpressure, wrong-type grants, reset mid-read and stall
// saturation. Read data expected by the core is kept in exp_q.
module tb_shared_mem_port;

  localparam int BW = 160;
  localparam int AW = 24;
  localparam int SW = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_RD  = 3'd1;
  localparam logic [2:0] S_REQ_WR  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RSP     = 3'd4;

  localparam logic [BW-1:0] WD = {20{8'hA5}};
  localparam logic [BW-1:0] D0 = {5{32'hDEAD_0000}};
  localparam logic [BW-1:0] D1 = {5{32'h1111_2222}};
  localparam logic [BW-1:0] D2 = {5{32'h3333_4444}};
  localparam logic [BW-1:0] D3 = {5{32'h5555_6666}};
  localparam logic [BW-1:0] D4 = {5{32'h7777_8888}};
  localparam logic [BW-1:0] D5 = {5{32'h9999_AAAA}};

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_wdata = '0;
  logic [2:0]    cmd_wr_size = '0;
  logic          rsp_valid;
  logic [BW-1:0] rsp_data;
  logic          rsp_ready = 1'b0;
  logic          req_rd;
  logic          req_wr;
  logic          grant_rd = 1'b0;
  logic          grant_wr = 1'b0;
  logic [AW-1:0] addr;
  logic [BW-1:0] wr_data;
  logic [2:0]    wr_size;
  logic [BW-1:0] rd_data = '0;
  logic [SW-1:0] stall_cnt;
  logic          stall_clr = 1'b0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  shared_mem_port #(
    .BUS_SIZE(BW), .UNIT_SIZE(32), .ADDR_SIZE(AW), .RD_LATENCY(1), .STALL_W(SW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wr_size(cmd_wr_size),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready),
    .o_req_rd(req_rd), .o_req_wr(req_wr), .i_grant_rd(grant_rd), .i_grant_wr(grant_wr),
    .o_addr(addr), .o_wr_data(wr_data), .o_wr_size(wr_size), .i_rd_data(rd_data),
    .o_stall_cnt(stall_cnt), .i_stall_clr(stall_clr), .o_dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stall();
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("stall_clr", BW'(stall_cnt), BW'(0));
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    step();
    cmd_valid = 1'b0;
    chk("issue_state", BW'(dbg_state), BW'(we ? S_REQ_WR : S_REQ_RD));
  endtask

  // Accept a response: valid must be up and data must match the queue head.
  task automatic take_rsp(input string name);
    chk({name, "_valid"}, BW'(rsp_valid), BW'(1));
    if (exp_q.size() == 0) begin
      chk({name, "_queue"}, BW'(0), BW'(1));
    end else begin
      chk({name, "_data"}, rsp_data, exp_q.pop_front());
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({name, "_done_valid"}, BW'(rsp_valid), BW'(0));
    chk({name, "_done_state"}, BW'(dbg_state), BW'(S_IDLE));
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic          rst;
    logic          cmd_valid;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic          rsp_ready;
    logic          grant_rd;
    logic          grant_wr;
    logic [BW-1:0] rd_data;
    logic [2:0]    e_state;
    logic          e_ready;
    logic          e_req_rd;
    logic          e_req_wr;
    logic          e_rsp_valid;
    logic [BW-1:0] e_rsp_data;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_wr_data;
    logic [2:0]    e_size;
    logic [SW-1:0] e_stall;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic cv, input logic we, input logic [AW-1:0] a,
    input logic [2:0] sz, input logic rr, input logic gr, input logic gw,
    input logic [BW-1:0] rdd,
    input logic [2:0] es, input logic ery, input logic erd, input logic ewr,
    input logic erv, input logic [BW-1:0] erdata, input logic [AW-1:0] ea,
    input logic [BW-1:0] ewd, input logic [2:0] esz, input logic [SW-1:0] est);
    vec_t v;
    v.rst = r; v.cmd_valid = cv; v.cmd_we = we; v.cmd_addr = a; v.cmd_size = sz;
    v.rsp_ready = rr; v.grant_rd = gr; v.grant_wr = gw; v.rd_data = rdd;
    v.e_state = es; v.e_ready = ery; v.e_req_rd = erd; v.e_req_wr = ewr;
    v.e_rsp_valid = erv; v.e_rsp_data = erdata; v.e_addr = ea; v.e_wr_data = ewd;
    v.e_size = esz; v.e_stall = est;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    cmd_wdata = WD;
    //            rst cv we addr     sz rr gr gw rd  | state     ry rd wr rv rdata addr     wdata sz st
    tbl[0] = mk(1, 0, 0, 24'h000, 0, 0, 0, 0, '0,  S_IDLE,    1, 0, 0, 0, '0, 24'h000, '0, 0, 0);
    // Posted write, granted in its first REQ_WR cycle.
    tbl[1] = mk(0, 1, 1, 24'h010, 5, 0, 0, 0, '0,  S_REQ_WR,  0, 0, 1, 0, '0, 24'h010, WD, 5, 0);
    tbl[2] = mk(0, 0, 0, 24'h000, 0, 0, 0, 1, '0,  S_IDLE,    1, 0, 0, 0, '0, 24'h010, WD, 5, 0);
    // Read to 0x20, three ungranted cycles, then grant; data on G+1.
    tbl[3] = mk(0, 1, 0, 24'h020, 0, 0, 0, 0, '0,  S_REQ_RD,  0, 1, 0, 0, '0, 24'h020, WD, 0, 0);
    tbl[4] = mk(0, 0, 0, 24'h000, 0, 0, 0, 0, '0,  S_REQ_RD,  0, 1, 0, 0, '0, 24'h020, WD, 0, 1);
    tbl[5] = mk(0, 0, 0, 24'h000, 0, 0, 0, 0, '0,  S_REQ_RD,  0, 1, 0, 0, '0, 24'h020, WD, 0, 2);
    tbl[6] = mk(0, 0, 0, 24'h000, 0, 0, 0, 0, '0,  S_REQ_RD,  0, 1, 0, 0, '0, 24'h020, WD, 0, 3);
    tbl[7] = mk(0, 0, 0, 24'h000, 0, 0, 1, 0, D0,  S_RD_WAIT, 0, 0, 0, 0, '0, 24'h020, WD, 0, 3);
    tbl[8] = mk(0, 0, 0, 24'h000, 0, 0, 0, 0, D1,  S_RSP,     0, 0, 0, 1, D1, 24'h020, WD, 0, 3);
    tbl[9] = mk(0, 0, 0, 24'h000, 0, 1, 0, 0, D2,  S_IDLE,    1, 0, 0, 0, D1, 24'h020, WD, 0, 3);

    for (int i = 0; i < 10; i++) begin
      rst         = tbl[i].rst;
      cmd_valid   = tbl[i].cmd_valid;
      cmd_we      = tbl[i].cmd_we;
      cmd_addr    = tbl[i].cmd_addr;
      cmd_wr_size = tbl[i].cmd_size;
      rsp_ready   = tbl[i].rsp_ready;
      grant_rd    = tbl[i].grant_rd;
      grant_wr    = tbl[i].grant_wr;
      rd_data     = tbl[i].rd_data;
      step();
      chk($sformatf("v%0d_state", i),     BW'(dbg_state),  BW'(tbl[i].e_state));
      chk($sformatf("v%0d_cmd_ready", i), BW'(cmd_ready),  BW'(tbl[i].e_ready));
      chk($sformatf("v%0d_req_rd", i),    BW'(req_rd),     BW'(tbl[i].e_req_rd));
      chk($sformatf("v%0d_req_wr", i),    BW'(req_wr),     BW'(tbl[i].e_req_wr));
      chk($sformatf("v%0d_rsp_valid", i), BW'(rsp_valid),  BW'(tbl[i].e_rsp_valid));
      chk($sformatf("v%0d_rsp_data", i),  rsp_data,        tbl[i].e_rsp_data);
      chk($sformatf("v%0d_addr", i),      BW'(addr),       BW'(tbl[i].e_addr));
      chk($sformatf("v%0d_wr_data", i),   wr_data,         tbl[i].e_wr_data);
      chk($sformatf("v%0d_wr_size", i),   BW'(wr_size),    BW'(tbl[i].e_size));
      chk($sformatf("v%0d_stall", i),     BW'(stall_cnt),  BW'(tbl[i].e_stall));
    end
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    grant_rd = 1'b0; grant_wr = 1'b0;

    // ---- Backpressure, immediate-grant read to 0x30 ----
    clear_stall();
    issue(1'b0, 24'h030);
    grant_rd = 1'b1;
    step();
    grant_rd = 1'b0;
    chk("bp_wait_state", BW'(dbg_state), BW'(S_RD_WAIT));
    chk("bp_wait_valid", BW'(rsp_valid), BW'(0));
    rd_data = D3;
    exp_q.push_back(D3);
    step();
    // Third cycle after acceptance: 2 + RD_LATENCY.
    chk("bp_latency_valid", BW'(rsp_valid), BW'(1));
    chk("bp_stall_zero", BW'(stall_cnt), BW'(0));
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 24'h099;
      rd_data   = {5{$urandom}};
      step();
      chk($sformatf("bp%0d_valid", i),     BW'(rsp_valid), BW'(1));
      chk($sformatf("bp%0d_data", i),      rsp_data,       D3);
      chk($sformatf("bp%0d_cmd_ready", i), BW'(cmd_ready), BW'(0));
      chk($sformatf("bp%0d_req_wr", i),    BW'(req_wr),    BW'(0));
      chk($sformatf("bp%0d_addr", i),      BW'(addr),      BW'(24'h030));
    end
    cmd_valid = 1'b0;
    take_rsp("bp_rsp");
    chk("bp_addr_kept", BW'(addr), BW'(24'h030));

    // ---- Grants in IDLE, wrong-type grants in REQ_RD and REQ_WR ----
    clear_stall();
    grant_rd = 1'b1;
    grant_wr = 1'b1;
    step();
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    chk("idle_grant_state", BW'(dbg_state), BW'(S_IDLE));
    chk("idle_grant_stall", BW'(stall_cnt), BW'(0));
    issue(1'b0, 24'h040);
    for (int i = 0; i < 2; i++) begin
      grant_wr = 1'b1;
      step();
      chk($sformatf("wg%0d_state", i),  BW'(dbg_state), BW'(S_REQ_RD));
      chk($sformatf("wg%0d_req_rd", i), BW'(req_rd),    BW'(1));
      chk($sformatf("wg%0d_stall", i),  BW'(stall_cnt), BW'(i + 1));
    end
    grant_wr = 1'b0;
    grant_rd = 1'b1;
    step();
    grant_rd = 1'b0;
    chk("wg_grant_state", BW'(dbg_state), BW'(S_RD_WAIT));
    chk("wg_grant_stall", BW'(stall_cnt), BW'(2));
    rd_data = D4;
    exp_q.push_back(D4);
    step();
    rd_data = D0;
    chk("wg_rsp_state", BW'(dbg_state), BW'(S_RSP));
    take_rsp("wg_rsp");
    issue(1'b1, 24'h044);
    grant_rd = 1'b1;
    step();
    grant_rd = 1'b0;
    chk("wgw_state", BW'(dbg_state), BW'(S_REQ_WR));
    chk("wgw_req_wr", BW'(req_wr), BW'(1));
    chk("wgw_stall", BW'(stall_cnt), BW'(3));
    grant_wr = 1'b1;
    step();
    grant_wr = 1'b0;
    chk("wgw_done_state", BW'(dbg_state), BW'(S_IDLE));
    chk("wgw_done_stall", BW'(stall_cnt), BW'(3));

    // ---- Reset while waiting for read data ----
    clear_stall();
    issue(1'b0, 24'h050);
    step();
    chk("rst_pre_stall", BW'(stall_cnt), BW'(1));
    grant_rd = 1'b1;
    step();
    grant_rd = 1'b0;
    chk("rst_pre_state", BW'(dbg_state), BW'(S_RD_WAIT));
    rst = 1'b1;
    rd_data = D5;
    step();
    rst = 1'b0;
    chk("rst_state", BW'(dbg_state), BW'(S_IDLE));
    chk("rst_req_rd", BW'(req_rd), BW'(0));
    chk("rst_rsp_valid", BW'(rsp_valid), BW'(0));
    chk("rst_cmd_ready", BW'(cmd_ready), BW'(1));
    chk("rst_stall", BW'(stall_cnt), BW'(0));
    chk("rst_addr", BW'(addr), BW'(0));
    step();
    chk("rst_after_valid", BW'(rsp_valid), BW'(0));
    chk("rst_after_data", rsp_data, BW'(0));

    // ---- Stall saturation and clear priority ----
    issue(1'b1, 24'h060);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat%0d_stall", i), BW'(stall_cnt), BW'((i > 15) ? 15 : i));
    end
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("sat_clr_stall", BW'(stall_cnt), BW'(0));
    chk("sat_clr_req_wr", BW'(req_wr), BW'(1));
    step();
    chk("sat_recount", BW'(stall_cnt), BW'(1));
    grant_wr = 1'b1;
    step();
    grant_wr = 1'b0;
    chk("sat_done_state", BW'(dbg_state), BW'(S_IDLE));
    chk("sat_done_stall", BW'(stall_cnt), BW'(1));

    chk("sb_empty", BW'(exp_q.size()), BW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shared_mem_port.md
Name: shared_mem_port

Overview:
Processor-side requester for the shared scratchpad. It accepts one load/store command at a time from a SIMD processor core. It drives the scratchpad's per-port request, address, write-data and write-size lines, and holds them until the arbiter grants the port. For reads, it captures the returned bus data and presents it to the core with a valid/ready handshake. One instance sits between each core and one port of the shared memory.

Parameters:
BUS_SIZE, 160, width of read/write data bus in bits
UNIT_SIZE, 32, width of one memory word in bits; BUS_SIZE/UNIT_SIZE = words per bus beat
ADDR_SIZE, 24, address width in bits
RD_LATENCY, 1, cycles from grant cycle to valid i_rd_data (legal 0..7)
STALL_W, 16, width of saturating stall counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  core presents a command
o_cmd_ready  out  1  port can accept a command (high only in IDLE)
i_cmd_we  in  1  1 = write, 0 = read
i_cmd_addr  in  ADDR_SIZE  command address
i_cmd_wdata  in  BUS_SIZE  write data
i_cmd_wr_size  in  3  number of UNIT_SIZE words to write
o_rsp_valid  out  1  read data valid
o_rsp_data  out  BUS_SIZE  read data
i_rsp_ready  in  1  core accepts read data
o_req_rd  out  1  read request to scratchpad arbiter
o_req_wr  out  1  write request to scratchpad arbiter
i_grant_rd  in  1  read grant for this port
i_grant_wr  in  1  write grant for this port
o_addr  out  ADDR_SIZE  address to scratchpad (shared for read and write)
o_wr_data  out  BUS_SIZE  write data to scratchpad
o_wr_size  out  3  write size to scratchpad
i_rd_data  in  BUS_SIZE  scratchpad read bus (shared by all ports)
o_stall_cnt  out  STALL_W  cycles spent requesting without grant, saturating
i_stall_clr  in  1  synchronous clear of o_stall_cnt

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous, active-high.
- Reset state: FSM = IDLE. Outputs: o_cmd_ready=1 (IDLE), o_req_rd=0, o_req_wr=0, o_rsp_valid=0, o_rsp_data=0, o_addr=0, o_wr_data=0, o_wr_size=0, o_stall_cnt=0.
- States: IDLE, REQ_RD, REQ_WR, RD_WAIT, RSP.
- IDLE: o_cmd_ready=1. On i_cmd_valid, register addr/wdata/wr_size into the o_addr/o_wr_data/o_wr_size registers. Go to REQ_WR if i_cmd_we=1, else REQ_RD.
- REQ_RD / REQ_WR:
  - o_req_rd / o_req_wr are Moore outputs, high for every cycle in the state. Exactly one is high.
  - o_addr, o_wr_data, o_wr_size are held stable.
  - The grant cycle G is the cycle in which the matching grant is sampled high.
- REQ_WR on grant: the write commits in cycle G. Next state is IDLE; o_req_wr=0 in G+1. Writes are posted; no response is generated.
- REQ_RD on grant:
  - RD_LATENCY=0: i_rd_data is sampled at the end of G into o_rsp_data; next state RSP.
  - RD_LATENCY>0: next state RD_WAIT with a down-counter loaded with RD_LATENCY-1. When the counter is 0, sample i_rd_data at the end of that cycle (cycle G+RD_LATENCY) and go to RSP.
- RD_WAIT: requests low. o_addr is still held, to cover a registered-address memory.
- RSP: o_rsp_valid=1 and o_rsp_data stable until i_rsp_ready=1. Then go to IDLE; o_rsp_valid=0 the next cycle.
- Mismatched grants:
  - i_grant_wr in REQ_RD, or i_grant_rd in REQ_WR, is ignored.
  - Any grant in IDLE, RD_WAIT or RSP is ignored.
- Throughput and latency:
  - Minimum of 2 cycles per write (IDLE, REQ_WR with immediate grant).
  - Read latency from command acceptance to o_rsp_valid = 2 + RD_LATENCY cycles with immediate grant.
- Stall counter:
  - Increments by 1 on each cycle in REQ_RD/REQ_WR whose matching grant is low.
  - Saturates at all-ones; no wrap.
  - i_stall_clr has priority over increment.
  - Not cleared by command completion.
- i_cmd_wr_size is passed through unchecked. Values 0 or > BUS_SIZE/UNIT_SIZE are the core's responsibility.
- Reset mid-operation:
  - Any state returns to IDLE and requests drop the next cycle.
  - A pending response is discarded.
  - o_stall_cnt is cleared.
- i_cmd_valid outside IDLE is ignored; no command is queued.

Test Plan:
1. Write, immediate grant: cmd we=1, addr=0x000010, wdata=0xA5..A5, size=5, grant_wr high in the first REQ_WR cycle -> o_req_wr high for exactly 1 cycle with o_addr=0x10 and o_wr_size=5; o_cmd_ready returns high the next cycle; o_stall_cnt=0.
2. Read, RD_LATENCY=1, grant after 3 cycles: cmd we=0, addr=0x20 -> o_req_rd high 4 cycles; o_stall_cnt=3; o_rsp_data equals i_rd_data driven in G+1; o_rsp_valid rises in G+2.
3. Response backpressure: i_rsp_ready held low 5 cycles -> o_rsp_valid and o_rsp_data stable for all 5 cycles; o_cmd_ready=0; a new i_cmd_valid is ignored; i_rd_data toggles are not captured.
4. Wrong-type grant: in REQ_RD assert i_grant_wr for 2 cycles, then i_grant_rd -> no state change during the i_grant_wr cycles; response occurs only after i_grant_rd; stall increments during the i_grant_wr cycles.
5. Reset mid-read: i_rst asserted in RD_WAIT -> next cycle IDLE, o_req_rd=0, o_rsp_valid stays 0, o_cmd_ready=1, o_stall_cnt=0.
6. Stall saturation with STALL_W=4: hold grant low 20 cycles -> o_stall_cnt stops at 15. i_stall_clr asserted in the same cycle as an ungranted request -> count reads 0 next cycle.
